uart_tx_frame: RTL and testbench
================================

UART_TX_FRAME -- requirements
Module: uart_tx_frame

Interface
REQ-001 Parameter DATA_WIDTH, default 8, payload bits per frame; legal range 5..9.
REQ-002 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1, 2.
REQ-003 clk  input  1  single clock; one frame bit per clk cycle.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 p_data  input  DATA_WIDTH  payload; sampled only on acceptance.
REQ-006 data_valid  input  1  request to send p_data.
REQ-007 par_en  input  1  1 = insert parity bit; sampled on acceptance.
REQ-008 par_typ  input  1  0 = even, 1 = odd; sampled on acceptance.
REQ-009 tx_out  output  1  registered serial line; idle high.
REQ-010 busy  output  1  high while a new request cannot be accepted.

Function
REQ-011 FSM states IDLE, START, DATA, PARITY, STOP; state, bit counter and data shift register all clocked by clk.
REQ-012 Acceptance occurs at a rising edge where data_valid=1 and busy=0; p_data, par_en and par_typ are latched at that edge, and later changes do not affect the frame in flight.
REQ-013 Transitions: IDLE->START on acceptance; START->DATA; DATA->DATA until DATA_WIDTH bits are sent; DATA->PARITY if latched par_en=1, else DATA->STOP; PARITY->STOP; STOP->STOP until STOP_BITS bits are sent; last STOP->START on acceptance, else ->IDLE.
REQ-014 Line value selected per state: IDLE 1, START 0, DATA current payload bit (LSB first), PARITY computed parity, STOP 1.
REQ-015 tx_out is the selected line value registered on clk; the output is glitch-free and has one cycle latency from state.
REQ-016 For acceptance at edge E0, frame bit k (k=0 is the start bit) is driven on tx_out from edge E(k+1) to E(k+2).
REQ-017 Frame length F = 1 + DATA_WIDTH + latched par_en + STOP_BITS cycles.
REQ-018 Parity is the XOR of all latched payload bits for even; its inverse for odd.
REQ-019 busy = (state != IDLE) and not (state == STOP and final stop bit); busy is a decode of registered state.
REQ-020 Acceptance during the final STOP cycle starts the next frame with zero idle cycles between frames.
REQ-021 data_valid while busy=1 is ignored and not queued; the requester must hold data_valid until busy=0.
REQ-022 Bit counter width is ceil(log2(DATA_WIDTH+1)); the counter reloads on each state entry and never wraps mid-state.

Reset
REQ-023 rst=1 immediately forces tx_out=1, busy=0, state=IDLE, counter=0 and shift register=0, independent of clk.
REQ-024 rst asserted mid-frame abandons the frame; no remaining bits are emitted after rst deasserts.
REQ-025 The first acceptance is possible at the first rising edge after rst deasserts.

Configuration
REQ-026 Macro UART_TX_PARITY_EN defined: the PARITY state, parity generator, par_en and par_typ behave as in REQ-007/008/013/018.
REQ-027 Macro UART_TX_PARITY_EN undefined: no parity logic is synthesised; par_en and par_typ remain ports but are ignored; DATA always goes to STOP; F = 1 + DATA_WIDTH + STOP_BITS.

Verification
REQ-028 Defaults, p_data=0xA5, par_en=0 -> tx_out sequence 0,1,0,1,0,0,1,0,1,1, then 1 idle; busy high for 9 cycles from acceptance.
REQ-029 Macro defined, p_data=0xA5, par_en=1: par_typ=0 -> parity bit 0; par_typ=1 -> parity bit 1; frame is 11 bits.
REQ-030 data_valid held high with 0x00 then 0xFF -> second start bit immediately follows the first stop bit; no idle-high cycle between frames.
REQ-031 rst pulsed during data bit 3 of 0x0F -> tx_out=1 within the same cycle, busy=0; no further 0 on tx_out until a new acceptance.
REQ-032 STOP_BITS=2, DATA_WIDTH=5, p_data=5'h15 -> sequence 0,1,0,1,0,1,1,1; busy low only in the second stop cycle.
REQ-033 p_data changed to 0x00 one cycle after acceptance of 0x3C -> transmitted payload is still 0x3C.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART frame serializer: start bit, LSB-first payload, optional parity, 1-2 stop bits.
// Latency: frame bit k appears on tx_out k+1 cycles after the acceptance edge.
// Backpressure: requests are taken only while busy=0 and are never queued.
//
// Ports:
//   clk        - single clock, one frame bit per cycle
//   rst        - asynchronous active-high reset
//   p_data     - payload, latched on acceptance
//   data_valid - send request, honoured at an edge where busy=0
//   par_en     - insert parity bit (latched on acceptance)
//   par_typ    - 0 = even, 1 = odd parity (latched on acceptance)
//   tx_out     - registered serial line, idle high
//   busy       - high while a new request cannot be accepted
//
// Build option: define UART_TX_PARITY_EN to include the parity state and
// generator. Without it, par_en/par_typ are ignored and no parity logic exists.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_tx;
`ifdef UART_TX_PARITY_EN
    logic                  r_par_en;
    logic                  r_par;
`else
    // Parity inputs are accepted at the port but intentionally have no load.
    wire                   w_unused_par = par_en ^ par_typ;
`endif

    wire w_last_data = (r_cnt == CW'(DATA_WIDTH - 1));
    wire w_last_stop = (r_state == STOP) && (r_cnt == CW'(STOP_BITS - 1));

    // The final stop cycle already counts as free so frames can abut.
    assign busy = (r_state != IDLE) && !w_last_stop;

    wire w_accept = data_valid && !busy;

    // Line value for the current state; registered below for a glitch-free output.
    logic w_line;
    always_comb begin
        w_line = 1'b1;
        case (r_state)
            START:  w_line = 1'b0;
            DATA:   w_line = r_shift[0];
`ifdef UART_TX_PARITY_EN
            PARITY: w_line = r_par;
`endif
            default: w_line = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_par_en <= 1'b0;
            r_par    <= 1'b0;
`endif
        end else begin
            r_tx <= w_line;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state  <= START;
                        r_cnt    <= '0;
                        r_shift  <= p_data;
`ifdef UART_TX_PARITY_EN
                        r_par_en <= par_en;
                        r_par    <= (^p_data) ^ par_typ;
`endif
                    end
                end
                START: begin
                    r_state <= DATA;
                    r_cnt   <= '0;
                end
                DATA: begin
                    r_shift <= r_shift >> 1;
                    if (w_last_data) begin
                        r_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                        r_state <= r_par_en ? PARITY : STOP;
`else
                        r_state <= STOP;
`endif
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    r_state <= STOP;
                    r_cnt   <= '0;
                end
`endif
                STOP: begin
                    if (w_last_stop) begin
                        r_cnt <= '0;
                        if (w_accept) begin
                            r_state  <= START;
                            r_shift  <= p_data;
`ifdef UART_TX_PARITY_EN
                            r_par_en <= par_en;
                            r_par    <= (^p_data) ^ par_typ;
`endif
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign tx_out = r_tx;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: default 8N1 instance driven through a scoreboard,
// plus a 5-bit / 2-stop instance for the short-frame case.
// Honours UART_TX_PARITY_EN the same way the design does.
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] p_data = 8'h00;
    logic       data_valid = 1'b0;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic       tx_out;
    logic       busy;

    logic [4:0] p_data5 = 5'h00;
    logic       dv5 = 1'b0;
    logic       tx5;
    logic       busy5;

    int n_vec = 0;
    int n_err = 0;

    bit exp_tx[$];
    bit exp_busy[$];

    always #5 clk = ~clk;

    uart_tx_frame dut (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_en     (par_en),
        .par_typ    (par_typ),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    uart_tx_frame #(.DATA_WIDTH(5), .STOP_BITS(2)) dut5 (
        .clk        (clk),
        .rst        (rst),
        .p_data     (p_data5),
        .data_valid (dv5),
        .par_en     (1'b0),
        .par_typ    (1'b0),
        .tx_out     (tx5),
        .busy       (busy5)
    );

    task automatic chk(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    // One clock: at the falling edge compare the line and busy with the model
    // (idle line and busy=0 when nothing is pending).
    task automatic cycle();
        bit et;
        bit eb;
        @(negedge clk);
        et = (exp_tx.size() != 0) ? exp_tx.pop_front() : 1'b1;
        eb = (exp_busy.size() != 0) ? exp_busy.pop_front() : 1'b0;
        chk("tx_out", tx_out, et);
        chk("busy", busy, eb);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Called just after a falling edge when the model says the DUT is free;
    // the next rising edge is the acceptance edge.
    task automatic send(input logic [7:0] d, input bit pe, input bit pt);
        int f;
        f = 1 + 8 + 1;
`ifdef UART_TX_PARITY_EN
        if (pe) f++;
`endif
        // From idle the cycle after acceptance still shows the idle line;
        // back-to-back, the previous stop bit is still queued there.
        if (exp_tx.size() == 0) exp_tx.push_back(1'b1);
        exp_tx.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_tx.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        if (pe) exp_tx.push_back((^d) ^ pt);
`endif
        exp_tx.push_back(1'b1);
        for (int i = 0; i < f - 1; i++) exp_busy.push_back(1'b1);
        exp_busy.push_back(1'b0);

        p_data     = d;
        par_en     = pe;
        par_typ    = pt;
        data_valid = 1'b1;
        cycle();
        // Disturb every latched input right after acceptance.
        data_valid = 1'b0;
        p_data     = ~d;
        par_en     = ~pe;
        par_typ    = ~pt;
    endtask

    bit exp5 [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        // Reset state, asynchronous and before any clock edge.
        rst = 1'b1;
        #1;
        chk("rst_tx_async", tx_out, 1'b1);
        chk("rst_busy_async", busy, 1'b0);
        idle(2);
        rst = 1'b0;

        // Acceptance on the first edge after reset release; 0xA5 8N1.
        send(8'hA5, 1'b0, 1'b0);
        idle(11);

        // Payload changed right after acceptance must not leak into the frame.
        send(8'h3C, 1'b0, 1'b0);
        idle(11);

        // Parity requests (ignored when parity is not built in).
        send(8'hA5, 1'b1, 1'b0);
        idle(12);
        send(8'hA5, 1'b1, 1'b1);
        idle(12);

        // Back-to-back: request held high through the first frame.
        send(8'h00, 1'b0, 1'b0);
        data_valid = 1'b1;
        p_data     = 8'hFF;
        idle(9);
        send(8'hFF, 1'b0, 1'b0);
        idle(11);

        // Reset while data bit 3 of 0x0F is on the line.
        send(8'h0F, 1'b0, 1'b0);
        idle(5);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_tx", tx_out, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        exp_tx.delete();
        exp_busy.delete();
        idle(2);
        rst = 1'b0;
        idle(12);

        // Recovery after the abandoned frame.
        send(8'h5A, 1'b0, 1'b0);
        idle(11);

        // Short frame: 5 data bits, 2 stop bits, payload 5'h15.
        p_data5 = 5'h15;
        dv5     = 1'b1;
        @(negedge clk);
        dv5     = 1'b0;
        p_data5 = 5'h00;
        chk("w5_tx_acc", tx5, 1'b1);
        chk("w5_busy_acc", busy5, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("w5_tx", tx5, exp5[k]);
            chk("w5_busy", busy5, (k < 6) ? 1'b1 : 1'b0);
        end
        @(negedge clk);
        chk("w5_tx_idle", tx5, 1'b1);
        chk("w5_busy_idle", busy5, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
